// File: rtl/load_store_unit.sv
// Load/store unit: CPU byte/half/word requests onto a single-cycle word-addressed memory port.
// Latency from acceptance to resp_valid: error 1, load 2, word store 2, sub-word store (read-modify-write) 3 cycles.
// Backpressure: req_ready high only in IDLE; no response backpressure (resp_valid is a one-cycle pulse).
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   req_*                request handshake (valid/ready) with write, size, unsigned, addr, wdata
//   resp_*               completion pulse, extended load data, error flag
//   mem_*                word-addressed memory port: address, write data/strobe, read enable, read data
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module load_store_unit #(
    parameter int MEM_WORDS = 1025
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_data_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [15:0] wdata_q;   // only the low half is needed after acceptance (word stores use req_wdata directly)

    logic [31:0] req_idx;
    logic        req_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state == S_IDLE);
    assign req_idx   = {2'b00, req_addr[31:2]};

    // Request rejection; out-of-range index is always an error.
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        if (req_idx >= 32'(MEM_WORDS))
            req_err = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_size == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = mem_data_in[7:0];
            2'd1:    rd_byte = mem_data_in[15:8];
            2'd2:    rd_byte = mem_data_in[23:16];
            default: rd_byte = mem_data_in[31:24];
        endcase
        rd_half = lane_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];

        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_ext = mem_data_in;
        endcase

        merged = mem_data_in;
        if (size_q == 2'b00) begin
            case (lane_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            lane_q         <= 2'b00;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            wdata_q        <= 16'h0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_err       <= 1'b0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lane_q      <= req_addr[1:0];
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        wdata_q     <= req_wdata[15:0];
                        mem_address <= req_idx;
                        resp_rdata  <= 32'h0;
                        resp_err    <= 1'b0;
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else if (!req_write) begin
                            mem_read <= 1'b1;
                            state    <= S_READ;
                        end else if (req_size == 2'b10) begin
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                            state          <= S_WRITE;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= S_RMW_READ;
                        end
                    end
                end
                S_READ: begin
                    mem_read   <= 1'b0;
                    resp_rdata <= load_ext;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RMW_READ: begin
                    mem_read       <= 1'b0;
                    mem_write_data <= merged;
                    mem_write      <= 1'b1;
                    state          <= S_WRITE;
                end
                S_WRITE: begin
                    // Memory commits the word at this edge.
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_data_in;

    int checks = 0;
    int errors = 0;

    // Attached memory: combinational read, write at posedge; poke port preloads words.
    logic [31:0] mem [0:2047];
    logic        poke_en;
    logic [10:0] poke_idx;
    logic [31:0] poke_dat;

    always #5 clk = ~clk;

    assign mem_data_in = (mem_address < 32'd2048) ? mem[mem_address[10:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write && mem_address < 32'd2048)
            mem[mem_address[10:0]] <= mem_write_data;
        else if (poke_en)
            mem[poke_idx] <= poke_dat;
    end

    load_store_unit #(.MEM_WORDS(1025)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_data_in    (mem_data_in)
    );

    task automatic poke(input logic [10:0] idx, input logic [31:0] dat);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_dat = dat;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    // Issues one request and observes it until resp_valid (bounded); lat = -1 if no response.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic err,
                           output int nrd, output int nwr,
                           output logic [31:0] wdat, output logic [31:0] waddr);
        int guard;
        lat = -1; rd = '0; err = 1'b0; nrd = 0; nwr = 0; wdat = '0; waddr = '0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wdat  = mem_write_data;
                waddr = mem_address;
            end
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                err = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #7;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL rst_mem_address got %h want 0", mem_address); end
        checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL rst_mem_write_data got %h want 0", mem_write_data); end
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_strobes got wr=%b rd=%b want 0 0", mem_write, mem_read); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_word_store_load;
        int lat, nrd, nwr;
        logic [31:0] rd, wdat, waddr;
        logic err;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, err, nrd, nwr, wdat, waddr);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wst_latency got %0d want 2", lat); end
        checks++; if (nwr !== 1 || nrd !== 0) begin errors++; $display("FAIL wst_strobes got wr=%0d rd=%0d want 1 0", nwr, nrd); end
        checks++; if (waddr !== 32'h4 || wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL wst_port got addr=%h data=%h want 4 deadbeef", waddr, wdat); end
        checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wst_resp got err=%b rdata=%h want 0 0", err, rd); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wst_mem got %h want deadbeef", mem[4]); end
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err, nrd, nwr, wdat, waddr);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wld_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL wld_data got %h err=%b want deadbeef 0", rd, err); end
        checks++; if (nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL wld_strobes got rd=%0d wr=%0d want 1 0", nrd, nwr); end
    endtask

    task automatic test_subword_store;
        int lat, nrd, nwr;
        logic [31:0] rd, wdat, waddr;
        logic err;
        poke(11'd4, 32'h11223344);
        // Upper wdata bits must not leak into the merged word.
        run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5, lat, rd, err, nrd, nwr, wdat, waddr);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bst_latency got %0d want 3", lat); end
        checks++; if (nrd !== 1 || nwr !== 1) begin errors++; $display("FAIL bst_strobes got rd=%0d wr=%0d want 1 1", nrd, nwr); end
        checks++; if (wdat !== 32'hA5223344 || waddr !== 32'h4) begin errors++; $display("FAIL bst_merge got %h @%h want a5223344 @4", wdat, waddr); end
        checks++; if (mem[4] !== 32'hA5223344) begin errors++; $display("FAIL bst_mem got %h want a5223344", mem[4]); end
        poke(11'd8, 32'h01020304);
        run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFFBEEF, lat, rd, err, nrd, nwr, wdat, waddr);
        checks++; if (lat !== 3) begin errors++; $display("FAIL hst_latency got %0d want 3", lat); end
        checks++; if (wdat !== 32'hBEEF0304 || mem[8] !== 32'hBEEF0304) begin errors++; $display("FAIL hst_merge got port=%h mem=%h want beef0304", wdat, mem[8]); end
    endtask

    task automatic test_subword_loads;
        int lat, nrd, nwr;
        logic [31:0] rd, wdat, waddr;
        logic err;
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [4] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFA522, 32'h00003344};
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rd, err, nrd, nwr, wdat, waddr);
            checks++;
            if (rd !== exps[i] || lat !== 2 || err !== 1'b0) begin
                errors++;
                $display("FAIL subload_%0d got data=%h lat=%0d err=%b want %h 2 0", i, rd, lat, err, exps[i]);
            end
        end
    endtask

    task automatic test_errors;
        int lat, nrd, nwr;
        logic [31:0] rd, wdat, waddr;
        logic err;
        poke(11'd0, 32'hCAFEF00D);
        run_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, lat, rd, err, nrd, nwr, wdat, waddr);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++; if (err !== 1'b1 || lat !== 1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_word got err=%b lat=%0d data=%h want 1 1 0", err, lat, rd); end
        checks++; if (nrd !== 0 || nwr !== 0) begin errors++; $display("FAIL misalign_word_access got rd=%0d wr=%0d want 0 0", nrd, nwr); end
        run_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat, rd, err, nrd, nwr, wdat, waddr);
        checks++; if (err !== 1'b1 || lat !== 1 || nrd !== 0) begin errors++; $display("FAIL misalign_half got err=%b lat=%0d rd=%0d want 1 1 0", err, lat, nrd); end
`else
        checks++; if (err !== 1'b0 || lat !== 2 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL misalign_word got err=%b lat=%0d data=%h want 0 2 cafef00d", err, lat, rd); end
        checks++; if (nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL misalign_word_access got rd=%0d wr=%0d want 1 0", nrd, nwr); end
        run_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat, rd, err, nrd, nwr, wdat, waddr);
        checks++; if (err !== 1'b0 || rd !== 32'h00003344) begin errors++; $display("FAIL misalign_half got err=%b data=%h want 0 00003344", err, rd); end
`endif
        run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, lat, rd, err, nrd, nwr, wdat, waddr);
        checks++; if (err !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0) begin errors++; $display("FAIL bad_size got err=%b lat=%0d rd=%0d wr=%0d want 1 1 0 0", err, lat, nrd, nwr); end
        checks++; if (mem[4] !== 32'hA5223344) begin errors++; $display("FAIL bad_size_mem got %h want a5223344", mem[4]); end
        run_req(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, lat, rd, err, nrd, nwr, wdat, waddr);
        checks++; if (err !== 1'b1 || lat !== 1 || nrd !== 0 || rd !== 32'h0) begin errors++; $display("FAIL range_1025 got err=%b lat=%0d rd=%0d data=%h want 1 1 0 0", err, lat, nrd, rd); end
    endtask

    // Second request held on req_valid while a load is in flight.
    task automatic test_back_to_back;
        int acc;
        int seen;
        poke(11'd5, 32'h13579BDF);
        poke(11'd1024, 32'h0BADF00D);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_addr = 32'h1000;
        checks++; if (req_ready !== 1'b0 || mem_address !== 32'h5) begin errors++; $display("FAIL b2b_busy_read got ready=%b addr=%h want 0 5", req_ready, mem_address); end
        @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h13579BDF) begin errors++; $display("FAIL b2b_first_resp got vld=%b data=%h want 1 13579bdf", resp_valid, resp_rdata); end
        checks++; if (req_ready !== 1'b0 || mem_address !== 32'h5) begin errors++; $display("FAIL b2b_busy_resp got ready=%b addr=%h want 0 5", req_ready, mem_address); end
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (mem_read && mem_address == 32'd1024) begin
                acc = 1;
                break;
            end
        end
        req_valid = 1'b0;
        checks++; if (acc !== 1) begin errors++; $display("FAIL b2b_accept got %0d want 1", acc); end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++; if (seen !== 1 || resp_rdata !== 32'h0BADF00D || resp_err !== 1'b0) begin errors++; $display("FAIL b2b_last_index got seen=%0d data=%h err=%b want 1 0badf00d 0", seen, resp_rdata, resp_err); end
    endtask

    task automatic test_reset_abort;
        int seen;
        poke(11'd6, 32'h55667788);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h18; req_wdata = 32'h00000099;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL abort_in_write got mem_write=%b want 1", mem_write); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL abort_strobes got wr=%b rd=%b want 0 0", mem_write, mem_read); end
        checks++; if (resp_valid !== 1'b0 || mem_address !== 32'h0) begin errors++; $display("FAIL abort_outputs got vld=%b addr=%h want 0 0", resp_valid, mem_address); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_resp got %0d pulses want 0", seen); end
        checks++; if (mem[6] !== 32'h55667788) begin errors++; $display("FAIL abort_mem got %h want 55667788", mem[6]); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", req_ready); end
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        poke_en = 1'b0; poke_idx = 11'h0; poke_dat = 32'h0;
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_subword_loads();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end

endmodule
